// File: rtl/user_simd_accel.sv
// OBI-attached SIMD lane accelerator: signed lane-wise arithmetic on two operand
// registers, processed LanesPerCycle lanes per clock with a done/irq handshake.
module user_simd_accel #(
    parameter int DataWidth     = 32,
    parameter int LaneWidth     = 8,
    parameter int LanesPerCycle = 1,
    parameter int IdWidth       = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [31:0]            addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [IdWidth-1:0]     aid_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [IdWidth-1:0]     rid_o,
    output logic                   err_o,
    output logic                   irq_o
);
    localparam int NumLanes = DataWidth / LaneWidth;
    localparam int NumSteps = NumLanes / LanesPerCycle;
    localparam int StepW    = (NumSteps > 1) ? $clog2(NumSteps) : 1;
    localparam int NumBytes = DataWidth / 8;
    localparam int ProdW    = 2 * LaneWidth;
    localparam int ExtW     = (ProdW > DataWidth) ? ProdW : DataWidth;
    localparam logic [StepW-1:0] LastStep = StepW'(NumSteps - 1);

    localparam logic [2:0] FuncAdd  = 3'd0;
    localparam logic [2:0] FuncSub  = 3'd1;
    localparam logic [2:0] FuncMul  = 3'd2;
    localparam logic [2:0] FuncMax  = 3'd3;
    localparam logic [2:0] FuncMin  = 3'd4;
    localparam logic [2:0] FuncSadd = 3'd5;
    localparam logic [2:0] FuncDot  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_reg;
    logic [DataWidth-1:0]   a_reg;
    logic [DataWidth-1:0]   b_reg;
    logic [DataWidth-1:0]   result_reg;
    logic [2:0]             func_reg;
    logic                   done_reg;
    logic                   irq_en_reg;
    logic [StepW-1:0]       step_reg;
    logic                   rvalid_reg;
    logic                   err_reg;
    logic [DataWidth-1:0]   rdata_reg;
    logic [IdWidth-1:0]     rid_reg;

    logic [2:0]             idx;
    logic                   busy;
    logic                   acc_err;
    logic                   wr_ok;
    logic                   start_req;
    logic                   status_w1c;
    logic [DataWidth-1:0]   wmask;
    logic [DataWidth-1:0]   a_merge;
    logic [DataWidth-1:0]   b_merge;
    logic [DataWidth-1:0]   read_mux;
    logic [DataWidth-1:0]   result_step;
    logic [DataWidth-1:0]   dot_sum;
    int                     lane_base;
    logic                   unused_addr_bits;

    logic [LanesPerCycle-1:0][LaneWidth-1:0] lane_res;
    logic [LanesPerCycle-1:0][DataWidth-1:0] dot_term;

    assign idx              = addr_i[4:2];
    assign busy             = (state_reg == RUN);
    assign unused_addr_bits = ^{addr_i[31:5], addr_i[1:0]};

    // RESULT is read-only; operands and CTRL are frozen while an operation runs.
    assign acc_err    = (idx > 3'd4) || (we_i && ((idx == 3'd3) || (busy && idx < 3'd3)));
    assign wr_ok      = req_i && we_i && !acc_err;
    assign start_req  = wr_ok && (idx == 3'd0) && be_i[3] && wdata_i[31];
    assign status_w1c = wr_ok && (idx == 3'd4) && be_i[0] && wdata_i[1];

    for (genvar gi = 0; gi < NumBytes; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{be_i[gi]}};
    end

    assign a_merge = (a_reg & ~wmask) | (wdata_i & wmask);
    assign b_merge = (b_reg & ~wmask) | (wdata_i & wmask);

    for (genvar gi = 0; gi < LanesPerCycle; gi++) begin : g_lane
        logic signed [LaneWidth-1:0] a_lane;
        logic signed [LaneWidth-1:0] b_lane;
        logic signed [LaneWidth:0]   sum_ext;
        logic        [LaneWidth-1:0] diff;
        logic signed [ProdW-1:0]     prod;
        logic signed [ExtW-1:0]      prod_ext;
        logic        [LaneWidth-1:0] lane_val;

        assign a_lane   = a_reg[(int'(step_reg) * LanesPerCycle + gi) * LaneWidth +: LaneWidth];
        assign b_lane   = b_reg[(int'(step_reg) * LanesPerCycle + gi) * LaneWidth +: LaneWidth];
        assign sum_ext  = a_lane + b_lane;
        assign diff     = a_lane - b_lane;
        assign prod     = a_lane * b_lane;
        assign prod_ext = prod;

        always_comb begin
            lane_val = '0;
            case (func_reg)
                FuncAdd: lane_val = sum_ext[LaneWidth-1:0];
                FuncSub: lane_val = diff;
                FuncMul: lane_val = prod[LaneWidth-1:0];
                FuncMax: lane_val = (a_lane > b_lane) ? a_lane : b_lane;
                FuncMin: lane_val = (a_lane < b_lane) ? a_lane : b_lane;
                FuncSadd: begin
                    // Overflow shows up as disagreement between the two top bits.
                    if (sum_ext[LaneWidth] != sum_ext[LaneWidth-1]) begin
                        lane_val = sum_ext[LaneWidth] ? {1'b1, {(LaneWidth-1){1'b0}}}
                                                      : {1'b0, {(LaneWidth-1){1'b1}}};
                    end else begin
                        lane_val = sum_ext[LaneWidth-1:0];
                    end
                end
                default: lane_val = '0;
            endcase
        end

        assign lane_res[gi] = lane_val;
        assign dot_term[gi] = prod_ext[DataWidth-1:0];
    end

    always_comb begin
        lane_base   = int'(step_reg) * LanesPerCycle;
        dot_sum     = '0;
        result_step = result_reg;
        for (int j = 0; j < LanesPerCycle; j++) begin
            result_step[(lane_base + j) * LaneWidth +: LaneWidth] = lane_res[j];
            dot_sum = dot_sum + dot_term[j];
        end
        if (func_reg == FuncDot) begin
            result_step = result_reg + dot_sum;
        end
    end

    always_comb begin
        read_mux = '0;
        case (idx)
            3'd0:    read_mux = DataWidth'(func_reg);
            3'd1:    read_mux = a_reg;
            3'd2:    read_mux = b_reg;
            3'd3:    read_mux = result_reg;
            3'd4:    read_mux = DataWidth'({irq_en_reg, done_reg, busy});
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            func_reg   <= '0;
            done_reg   <= 1'b0;
            irq_en_reg <= 1'b0;
            step_reg   <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            rid_reg    <= '0;
        end else begin
            rvalid_reg <= req_i;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            if (req_i) begin
                rid_reg <= aid_i;
                err_reg <= acc_err;
                if (!we_i && !acc_err) begin
                    rdata_reg <= read_mux;
                end
            end

            if (wr_ok) begin
                case (idx)
                    3'd0: if (be_i[0]) func_reg <= wdata_i[2:0];
                    3'd1: a_reg <= a_merge;
                    3'd2: b_reg <= b_merge;
                    3'd4: if (be_i[0]) irq_en_reg <= wdata_i[2];
                    default: ;
                endcase
            end

            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        state_reg  <= RUN;
                        step_reg   <= '0;
                        result_reg <= '0;
                        done_reg   <= 1'b0;
                    end else if (status_w1c) begin
                        done_reg <= 1'b0;
                    end
                end
                RUN: begin
                    result_reg <= result_step;
                    // Completion sets done even if software clears it in the same cycle.
                    if (step_reg == LastStep) begin
                        state_reg <= IDLE;
                        step_reg  <= '0;
                        done_reg  <= 1'b1;
                    end else begin
                        step_reg <= step_reg + StepW'(1);
                        if (status_w1c) done_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_reg;
    assign rdata_o  = rdata_reg;
    assign rid_o    = rid_reg;
    assign err_o    = err_reg;
    assign irq_o    = done_reg & irq_en_reg;
endmodule
